// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver (and its matching transmitter).
//   - Parity mode constants PAR_NONE / PAR_ODD / PAR_EVEN
//   - Receiver FSM state encodings ST_*
//   - tick_div(): clocks per oversample tick, truncated, never below 1
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned baud,
                                           input int unsigned os);
    int unsigned div;
    div = clk_hz / (baud * os);
    if (div == 0) div = 1;
    return div;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Output handshake bundle of the UART receiver.
//   master (receiver): drives rx_data, rx_valid, parity_err, frame_err, overrun; reads rx_ready
//   slave  (consumer): reads the above, drives rx_ready
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : holds the counter at 0 (no tick) so the phase restarts when clr drops
//   tick       : one-cycle pulse when the counter reaches DIV-1
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = !clr && (cnt_q == CW'(DIV - 1));
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS payload, optional odd/even parity, 1 or 2 stop bits,
// OVERSAMPLE-times oversampling with a 3-sample majority vote per bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx         : asynchronous serial line, idle high
//   busy       : high from start detection until the frame is handed off
//   break_det  : (only with UART_RX_BREAK_DET_EN) one-cycle pulse on an all-zero frame
//   out_if     : rx_data / rx_valid / rx_ready handshake plus parity_err, frame_err, overrun
// Build option: define UART_RX_BREAK_DET_EN to add break detection.
module uart_rx_cfg import uart_pkg::*; #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic busy,
`ifdef UART_RX_BREAK_DET_EN
  output logic break_det,
`endif
  uart_rx_cfg_if.master out_if
);
  localparam int unsigned TickDiv = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] SampLo   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SampMid  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SampHi   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SampLast = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LastBit  = BW'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_sync_q;
  logic [2:0]           state_q, state_d;
  logic [SW-1:0]        s_idx_q, s_idx_d;
  logic [2:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 tick, decide, maj;

  uart_baud_tick #(.DIV(TickDiv)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == ST_IDLE),
    .tick  (tick)
  );

  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign decide = tick && (s_idx_q == SampLast);
  assign busy   = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    s_idx_d    = s_idx_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    armed_d    = armed_q;
    if (state_q != ST_IDLE && tick) begin
      s_idx_d = (s_idx_q == SampLast) ? '0 : s_idx_q + 1'b1;
      if (s_idx_q == SampLo || s_idx_q == SampMid || s_idx_q == SampHi) begin
        samp_d = {samp_q[1:0], rx_sync_q};
      end
    end
    case (state_q)
      ST_IDLE: begin
        // A line seen high re-arms start detection; it stays disarmed after a framing error.
        if (rx_sync_q) armed_d = 1'b1;
        if (armed_q && !rx_sync_q) begin
          state_d    = ST_START;
          s_idx_d    = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          par_d      = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      ST_START: if (decide) state_d = maj ? ST_IDLE : ST_DATA;
      ST_DATA: if (decide) begin
        shift_d   = {maj, shift_q[DATA_BITS-1:1]};
        par_d     = par_q ^ maj;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LastBit) state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (decide) begin
        perr_d  = (PARITY == PAR_ODD) ? ~(par_q ^ maj) : (par_q ^ maj);
        state_d = ST_STOP;
      end
      ST_STOP: if (decide) begin
        if (!maj) ferr_d = 1'b1;
        stop_cnt_d = 1'b1;
        if (stop_cnt_q || (STOP_BITS == 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (ferr_q) armed_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UART_RX_BREAK_DET_EN
  logic zero_q, zero_d, break_q, break_d;

  // Tracks whether every voted bit from the first data bit up to the first stop bit was 0.
  always_comb begin
    zero_d = zero_q;
    if (state_q == ST_IDLE) begin
      zero_d = 1'b1;
    end else if (decide && ((state_q == ST_DATA) || (state_q == ST_PARITY) ||
                            ((state_q == ST_STOP) && !stop_cnt_q))) begin
      zero_d = zero_q & ~maj;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q  <= 1'b0;
      break_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      break_q <= break_d;
    end
  end

  assign break_det = break_q;
`endif

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    break_d      = 1'b0;
`endif
    if (rx_valid_q && out_if.rx_ready) rx_valid_d = 1'b0;
    if (state_q == ST_DONE) begin
`ifdef UART_RX_BREAK_DET_EN
      if (zero_q) break_d = 1'b1; else
`endif
      // Loading in the accept cycle keeps valid high with no bubble.
      if (!rx_valid_q || out_if.rx_ready) begin
        rx_data_d    = shift_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      state_q      <= ST_IDLE;
      s_idx_q      <= '0;
      samp_q       <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      par_q        <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      armed_q      <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      state_q      <= state_d;
      s_idx_q      <= s_idx_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      par_q        <= par_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      armed_q      <= armed_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_if.rx_data    = rx_data_q;
  assign out_if.rx_valid   = rx_valid_q;
  assign out_if.parity_err = parity_err_q;
  assign out_if.frame_err  = frame_err_q;
  assign out_if.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three receivers (8N1, 7E1, 8N2) on one clock, 16 clocks per bit.
// Frames are built bit by bit; the expected payload and flags go into a per-receiver queue
// and a monitor pops and compares on every accepted transfer.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int BitClks = 16;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic busy_a, busy_b, busy_c;
  logic rdy_a = 1'b1;
  bit   rand_rdy_b = 1'b0;
  int   checks = 0, failures = 0;
  int   ovr_cnt = 0, brk_cnt = 0, brk_exp = 0;
  exp_t q_a[$], q_b[$], q_c[$];

`ifdef UART_RX_BREAK_DET_EN
  logic brk_a, brk_b, brk_c;
`endif

  uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if_b ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if_c ();

  uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .busy(busy_a),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk_a),
`endif
    .out_if(if_a)
  );

  uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .busy(busy_b),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk_b),
`endif
    .out_if(if_b)
  );

  uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .rx(rx_c), .busy(busy_c),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk_c),
`endif
    .out_if(if_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int id, input exp_t e);
    case (id)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic mon_accept(input int id, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    bit   empty;
    empty = 1'b1;
    case (id)
      0: if (q_a.size() > 0) begin e = q_a.pop_front(); empty = 1'b0; end
      1: if (q_b.size() > 0) begin e = q_b.pop_front(); empty = 1'b0; end
      default: if (q_c.size() > 0) begin e = q_c.pop_front(); empty = 1'b0; end
    endcase
    if (empty) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame dut=%0d actual=0x%0h required=none", id, d);
    end else begin
      check($sformatf("data_dut%0d", id), 32'(d), 32'(e.data));
      check($sformatf("parity_err_dut%0d", id), 32'(pe), 32'(e.perr));
      check($sformatf("frame_err_dut%0d", id), 32'(fe), 32'(e.ferr));
    end
  endtask

  // Monitor: samples on the falling edge, one accept per rising edge.
  always @(negedge clk) begin
    if (if_a.rx_valid && if_a.rx_ready) mon_accept(0, {1'b0, if_a.rx_data}, if_a.parity_err,
                                                   if_a.frame_err);
    if (if_b.rx_valid && if_b.rx_ready) mon_accept(1, {2'b0, if_b.rx_data}, if_b.parity_err,
                                                   if_b.frame_err);
    if (if_c.rx_valid && if_c.rx_ready) mon_accept(2, {1'b0, if_c.rx_data}, if_c.parity_err,
                                                   if_c.frame_err);
    ovr_cnt += int'(if_a.overrun) + int'(if_b.overrun) + int'(if_c.overrun);
`ifdef UART_RX_BREAK_DET_EN
    brk_cnt += int'(brk_a) + int'(brk_b) + int'(brk_c);
`endif
  end

  // Consumer: ready changes just after the rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if_a.rx_ready = rdy_a;
    if_b.rx_ready = rand_rdy_b ? 1'($urandom_range(0, 1)) : 1'b1;
    if_c.rx_ready = 1'b1;
  end

  task automatic set_rx(input int id, input logic v);
    case (id)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BitClks) @(negedge clk);
  endtask

  // id 0: 8N1, id 1: 7 bits even parity, id 2: 8N2. stop_low[s] drives stop bit s low.
  task automatic send_frame(input int id, input logic [8:0] data, input bit flip_par,
                            input bit [1:0] stop_low, input bit record);
    int   db, par, nstop;
    bit   bits[$];
    logic p, pb;
    exp_t e;
`ifdef UART_RX_BREAK_DET_EN
    bit   brk;
`endif
    db    = (id == 1) ? 7 : 8;
    par   = (id == 1) ? 2 : 0;
    nstop = (id == 2) ? 2 : 1;
    p     = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      bits.push_back(data[i]);
      p ^= data[i];
    end
    e.data = data & ((9'd1 << db) - 9'd1);
    e.perr = 1'b0;
    if (par != 0) begin
      pb = (par == 2) ? p : ~p;
      pb ^= flip_par;
      bits.push_back(pb);
      e.perr = (par == 1) ? ((p ^ pb) != 1'b1) : ((p ^ pb) != 1'b0);
    end
    e.ferr = 1'b0;
    for (int s = 0; s < nstop; s++) begin
      bits.push_back(!stop_low[s]);
      if (stop_low[s]) e.ferr = 1'b1;
    end
    if (record) begin
`ifdef UART_RX_BREAK_DET_EN
      brk = 1'b1;
      for (int i = 0; i <= db + ((par != 0) ? 1 : 0) + 1; i++) if (bits[i]) brk = 1'b0;
      if (brk) brk_exp++;
      else     push_exp(id, e);
`else
      push_exp(id, e);
`endif
    end
    foreach (bits[i]) begin
      set_rx(id, bits[i]);
      repeat (BitClks) @(negedge clk);
    end
    set_rx(id, 1'b1);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    repeat (4) @(negedge clk);
    check("reset_valid_a", 32'(if_a.rx_valid), 0);
    check("reset_busy_a", 32'(busy_a), 0);
    check("reset_data_a", 32'(if_a.rx_data), 0);
    check("reset_overrun_a", 32'(if_a.overrun), 0);
    check("reset_valid_b", 32'(if_b.rx_valid), 0);
    check("reset_valid_c", 32'(if_c.rx_valid), 0);
    rst_n = 1'b1;
    idle_bits(2);

    send_frame(0, 9'h0A5, 1'b0, 2'b00, 1'b1); idle_bits(1);
    send_frame(1, 9'h041, 1'b1, 2'b00, 1'b1); idle_bits(1);
    send_frame(1, 9'h041, 1'b0, 2'b00, 1'b1); idle_bits(1);
    send_frame(2, 9'h03C, 1'b0, 2'b10, 1'b1); idle_bits(1);

    // Short glitch: detected as a start, rejected by the vote.
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_busy_rise", 32'(busy_a), 1);
    n = 0;
    while (busy_a && n < 24) begin
      @(negedge clk);
      n++;
    end
    check("glitch_busy_fall", 32'(busy_a), 0);
    idle_bits(1);

    // Backpressure: the second frame is lost.
    rdy_a = 1'b0;
    idle_bits(1);
    send_frame(0, 9'h011, 1'b0, 2'b00, 1'b1); idle_bits(1);
    send_frame(0, 9'h022, 1'b0, 2'b00, 1'b0);
    repeat (8) @(negedge clk);
    check("ovr_count", 32'(ovr_cnt), 1);
    check("ovr_hold_valid", 32'(if_a.rx_valid), 1);
    check("ovr_hold_data", 32'(if_a.rx_data), 32'h11);
    rdy_a = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("ovr_valid_drop", 32'(if_a.rx_valid), 0);
    idle_bits(1);

    // Line held low for 20 bit times.
    e.data = 9'd0; e.perr = 1'b0; e.ferr = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
    brk_exp++;
`else
    push_exp(0, e);
`endif
    rx_a = 1'b0;
    repeat (20 * BitClks) @(negedge clk);
    check("held_low_no_retrigger", 32'(busy_a), 0);
    rx_a = 1'b1;
    idle_bits(2);
    send_frame(0, 9'h0C3, 1'b0, 2'b00, 1'b1); idle_bits(1);

    repeat (12) begin
      send_frame(0, 9'($urandom_range(0, 255)), 1'b0,
                 ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00, 1'b1);
      idle_bits($urandom_range(1, 3));
    end
    rand_rdy_b = 1'b1;
    repeat (12) begin
      send_frame(1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 2'b00, 1'b1);
      idle_bits($urandom_range(1, 3));
    end
    rand_rdy_b = 1'b0;
    repeat (12) begin
      send_frame(2, 9'($urandom_range(0, 255)), 1'b0, 2'($urandom_range(0, 3)), 1'b1);
      idle_bits($urandom_range(1, 3));
    end

    // Reset in the middle of the data bits.
    send_frame(0, 9'h096, 1'b0, 2'b00, 1'b1); idle_bits(1);
    fork
      send_frame(0, 9'h077, 1'b0, 2'b00, 1'b0);
      begin
        idle_bits(4);
        rst_n = 1'b0;
      end
    join
    @(negedge clk);
    check("midreset_valid", 32'(if_a.rx_valid), 0);
    check("midreset_busy", 32'(busy_a), 0);
    check("midreset_data", 32'(if_a.rx_data), 0);
    check("midreset_frame_err", 32'(if_a.frame_err), 0);
    rst_n = 1'b1;
    idle_bits(2);
    send_frame(0, 9'h05A, 1'b0, 2'b00, 1'b1);
    idle_bits(2);

    check("drain_a", 32'(q_a.size()), 0);
    check("drain_b", 32'(q_b.size()), 0);
    check("drain_c", 32'(q_c.size()), 0);
    check("overrun_total", 32'(ovr_cnt), 1);
    check("break_total", 32'(brk_cnt), 32'(brk_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds:
- configurable data width, parity and stop bits
- 16x oversampling with 3-sample majority vote and false-start rejection
- per-frame parity/framing error flags
- valid/ready output handshake with overrun detection

It feeds the command/operand parser of the matrix calculator from the board UART pin.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line bit rate.
- OVERSAMPLE, 16: sample ticks per bit. Must be ≥8 and even.
- DATA_BITS, 8: payload bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- rx, in, 1: asynchronous serial line, idle high.
- rx_data, out, DATA_BITS: received payload, LSB first on the wire.
- rx_valid, out, 1: rx_data and flags are valid; held until accepted.
- rx_ready, in, 1: consumer accepts when rx_valid && rx_ready.
- parity_err, out, 1: sideband of the current rx_data; 0 when PARITY=0.
- frame_err, out, 1: sideband; a stop bit was sampled low.
- overrun, out, 1: one-cycle pulse; a frame was dropped.
- busy, out, 1: high while a frame is being received.

Behaviour:
- Reset: reset is clk / rst_n, asynchronous, active-low. All outputs are 0, FSM goes to IDLE, counters are cleared. The 2-FF synchroniser on rx resets to 1. Reset mid-frame aborts the frame with no output.
- Tick generator:
  - TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation, clamped to ≥1.
  - Counter wraps at TICK_DIV-1 and emits a 1-cycle tick.
  - Counter is held at 0 in IDLE and restarts on start detection, so phase is aligned to the start edge.
- Sampling: within each bit, samples at tick indices OVERSAMPLE/2-1, /2 and /2+1 are majority-voted. The bit is decided at index OVERSAMPLE-1.
- FSM transitions:
  - IDLE→START on synchronised rx = 0.
  - START: if the voted start bit is 1, this is a false start; return to IDLE with no output. Otherwise go to DATA.
  - DATA shifts DATA_BITS bits LSB-first, then goes to PARITY if PARITY≠0, else STOP.
  - PARITY compares the voted bit with the computed parity (odd: XOR of data and parity = 1; even: XOR = 0). The mismatch is latched as a pending parity error.
  - STOP: each of the STOP_BITS bits is voted. Any 0 sets the pending frame error.
  - After the last stop-bit decision, go to DONE (1 cycle), then IDLE.
- busy is 1 in START..DONE.
- DONE behaviour:
  - If rx_valid=0, or rx_valid && rx_ready in that same cycle: load rx_data/parity_err/frame_err and set rx_valid on the next edge.
  - Otherwise keep the old data and flags and pulse overrun for 1 cycle; the new frame is lost.
- Latency: rx_valid rises 2 clk after the final stop-bit decision tick (DONE + register), plus 2 clk of synchroniser delay from the line.
- Handshake:
  - rx_valid clears on the edge after accept.
  - Data and flags are stable while rx_valid && !rx_ready.
  - Accept and a new load in the same cycle give back-to-back valid with no bubble.
- Frame error: data is still delivered, with frame_err=1. After a frame error the FSM waits in IDLE for rx to go high before arming start detection (no re-trigger on a held-low line).
- Width rules: the shift register is DATA_BITS wide. The bit counter is $clog2(DATA_BITS+1) wide, and the tick index $clog2(OVERSAMPLE) wide.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- When defined:
  - Adds output port break_det (1 bit, one-cycle pulse).
  - A frame where start, all data, parity (if present) and the first stop bit are all 0 pulses break_det in DONE.
  - Nothing is loaded to rx_data; rx_valid and overrun are unaffected.
  - The FSM waits for rx high before re-arming.
- When undefined: no break_det port; such a frame is delivered as data 0 with frame_err=1 (parity_err per the normal rule).

Decomposition:
- Package uart_pkg:
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, DONE)
  - function tick_div(clk, baud, os)
- Sub-module uart_baud_tick (parameter DIV; inputs clk, rst_n, clr; output tick) is natural and will be reused by the matching transmitter.

Test Plan:
- Bench clock: CLK_FREQ=16_000_000, BAUD_RATE=1_000_000, OVERSAMPLE=16, TICK_DIV=1.
- 8N1, send 0xA5, rx_ready=1 → one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0.
- DATA_BITS=7, PARITY=2, send 0x41 with parity bit 1 (wrong) → rx_data=0x41, parity_err=1; with parity bit 0 → parity_err=0.
- 8N1, 3-clk low glitch on idle line → no rx_valid, busy returns to 0 within 1 bit time.
- rx_ready=0, send 0x11 then 0x22 → rx_data stays 0x11, overrun pulses once at the end of frame 2; raise rx_ready → 0x11 accepted, rx_valid drops.
- STOP_BITS=2, second stop bit low on 0x3C → rx_data=0x3C, frame_err=1.
- Line held low for 20 bit times → with UART_RX_BREAK_DET_EN, one break_det pulse and no rx_valid; without it, one rx_valid with data 0x00 and frame_err=1, and no further frames until rx returns high.
- Assert rst_n low mid-DATA → outputs 0, next clean frame 0x5A received correctly.
